// File: rtl/snitch_icache_data_ctrl_pkg.sv
// rtl/snitch_icache_data_ctrl_pkg.sv - cache geometry type and helpers for the data array controller
package snitch_icache_data_ctrl_pkg;

    typedef struct packed {
        int unsigned SET_COUNT;
        int unsigned LINE_COUNT;
        int unsigned LINE_WIDTH;
    } config_t;

    localparam config_t DEFAULT_CFG = '{SET_COUNT: 2, LINE_COUNT: 128, LINE_WIDTH: 128};

    // Way index width; a direct-mapped cache still carries a 1-bit (ignored) way field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snitch_icache_data_ctrl_fifo.sv
// rtl/snitch_icache_data_ctrl_fifo.sv - 2-entry in-order response buffer
module snitch_icache_data_ctrl_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_i) wr_ptr <= ~wr_ptr;
            if (pop_i)  rd_ptr <= ~rd_ptr;
            case ({push_i, pop_i})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/snitch_icache_data_ctrl.sv
// rtl/snitch_icache_data_ctrl.sv - data array arbiter, SRAM driver and hit-line response path
module snitch_icache_data_ctrl
    import snitch_icache_data_ctrl_pkg::*;
#(
    parameter config_t     CFG         = DEFAULT_CFG,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned SET_ALIGN   = clog2_min1(CFG.SET_COUNT),
    parameter int unsigned COUNT_ALIGN = $clog2(CFG.LINE_COUNT)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    lookup_valid_i,
    output logic                                    lookup_ready_o,
    input  logic [COUNT_ALIGN-1:0]                  lookup_addr_i,
    input  logic [SET_ALIGN-1:0]                    lookup_way_i,
    input  logic [ID_WIDTH-1:0]                     lookup_id_i,
    output logic                                    rsp_valid_o,
    input  logic                                    rsp_ready_i,
    output logic [CFG.LINE_WIDTH-1:0]               rsp_data_o,
    output logic [ID_WIDTH-1:0]                     rsp_id_o,
    input  logic                                    write_valid_i,
    output logic                                    write_ready_o,
    input  logic [COUNT_ALIGN-1:0]                  write_addr_i,
    input  logic [SET_ALIGN-1:0]                    write_way_i,
    input  logic [CFG.LINE_WIDTH-1:0]               write_data_i,
    output logic [CFG.SET_COUNT-1:0]                ram_enable_o,
    output logic                                    ram_write_o,
    output logic [COUNT_ALIGN-1:0]                  ram_addr_o,
    output logic [CFG.SET_COUNT*CFG.LINE_WIDTH-1:0] ram_wdata_o,
    input  logic [CFG.SET_COUNT*CFG.LINE_WIDTH-1:0] ram_rdata_i
);

    localparam int unsigned SC = CFG.SET_COUNT;
    localparam int unsigned LW = CFG.LINE_WIDTH;

    typedef logic [LW-1:0] line_t;
    typedef struct packed {
        line_t               data;
        logic [ID_WIDTH-1:0] id;
    } rsp_t;

    logic [SET_ALIGN-1:0] lookup_way;
    logic [SET_ALIGN-1:0] write_way;
    logic                 read_fire;
    logic                 pop;
    logic                 credit_ok;
    logic [1:0]           count;
    logic [1:0]           outstanding;

    logic                 s1_valid;
    logic [SET_ALIGN-1:0] s1_way;
    logic [ID_WIDTH-1:0]  s1_id;

    line_t [SC-1:0]       rdata_ways;
    rsp_t                 push_entry;
    rsp_t                 head_entry;

    if (SC == 1) begin : gen_single_way
        assign lookup_way = '0;
        assign write_way  = '0;
    end else begin : gen_multi_way
        assign lookup_way = lookup_way_i;
        assign write_way  = write_way_i;
    end

    // A buffered entry is released this cycle if popped, so its slot can be re-credited immediately.
    assign outstanding    = count + {1'b0, s1_valid};
    assign pop            = rsp_valid_o && rsp_ready_i;
    assign credit_ok      = (outstanding < 2'd2) || pop;
    assign write_ready_o  = 1'b1;
    assign lookup_ready_o = !write_valid_i && credit_ok;
    assign read_fire      = lookup_valid_i && lookup_ready_o;

    always_comb begin
        ram_enable_o = '0;
        ram_write_o  = 1'b0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        if (write_valid_i) begin
            ram_enable_o = SC'(1) << write_way;
            ram_write_o  = 1'b1;
            ram_addr_o   = write_addr_i;
            ram_wdata_o  = {SC{write_data_i}};
        end else if (read_fire) begin
            ram_enable_o = SC'(1) << lookup_way;
            ram_addr_o   = lookup_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_way   <= '0;
            s1_id    <= '0;
        end else begin
            s1_valid <= read_fire;
            if (read_fire) begin
                s1_way <= lookup_way;
                s1_id  <= lookup_id_i;
            end
        end
    end

    assign rdata_ways      = ram_rdata_i;
    assign push_entry.data = rdata_ways[s1_way];
    assign push_entry.id   = s1_id;

    snitch_icache_data_ctrl_fifo #(
        .WIDTH ($bits(rsp_t))
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (s1_valid),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (count)
    );

    assign rsp_valid_o = (count != 2'd0);
    assign rsp_data_o  = head_entry.data;
    assign rsp_id_o    = head_entry.id;

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// tb/tb_snitch_icache_data_ctrl.sv - directed self-checking bench for snitch_icache_data_ctrl
module tb_snitch_icache_data_ctrl;
    import snitch_icache_data_ctrl_pkg::*;

    localparam config_t CFG = '{SET_COUNT: 2, LINE_COUNT: 128, LINE_WIDTH: 128};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lookup_valid;
    logic         lookup_ready;
    logic [6:0]   lookup_addr;
    logic [0:0]   lookup_way;
    logic [3:0]   lookup_id;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_id;
    logic         write_valid;
    logic         write_ready;
    logic [6:0]   write_addr;
    logic [0:0]   write_way;
    logic [127:0] write_data;
    logic [1:0]   ram_enable;
    logic         ram_write;
    logic [6:0]   ram_addr;
    logic [255:0] ram_wdata;
    logic [255:0] ram_rdata;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] LINE_A5  = {16{8'hA5}};
    localparam logic [127:0] LINE_D1  = {16{8'hD1}};
    localparam logic [127:0] LINE_OLD = {8{16'h1111}};
    localparam logic [127:0] LINE_NEW = {8{16'h2222}};

    always #5 clk = ~clk;

    snitch_icache_data_ctrl #(
        .CFG      (CFG),
        .ID_WIDTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .lookup_valid_i (lookup_valid),
        .lookup_ready_o (lookup_ready),
        .lookup_addr_i  (lookup_addr),
        .lookup_way_i   (lookup_way),
        .lookup_id_i    (lookup_id),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_id_o       (rsp_id),
        .write_valid_i  (write_valid),
        .write_ready_o  (write_ready),
        .write_addr_i   (write_addr),
        .write_way_i    (write_way),
        .write_data_i   (write_data),
        .ram_enable_o   (ram_enable),
        .ram_write_o    (ram_write),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    // Behavioural 1-cycle SRAM, one bank per way
    logic [127:0] mem [2][128];
    logic [127:0] rd  [2];

    always_ff @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (ram_enable[w]) begin
                if (ram_write) mem[w][ram_addr] <= ram_wdata[w*128 +: 128];
                else           rd[w] <= mem[w][ram_addr];
            end
        end
    end

    assign ram_rdata = {rd[1], rd[0]};

    function automatic logic [127:0] pat(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_write(input logic v, input logic [6:0] a, input logic w, input logic [127:0] d);
        write_valid = v;
        write_addr  = a;
        write_way   = w;
        write_data  = d;
    endtask

    task automatic set_read(input logic v, input logic [6:0] a, input logic w, input logic [3:0] id);
        lookup_valid = v;
        lookup_addr  = a;
        lookup_way   = w;
        lookup_id    = id;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set_write(1'b0, 7'd0, 1'b0, '0);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_enable", ram_enable, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_lookup_ready", lookup_ready, 1);
        rst_n = 1'b1;

        // 1: write then read the same line in way 1
        @(negedge clk);
        set_write(1'b1, 7'd5, 1'b1, LINE_A5);
        #1;
        chk("t1_wr_enable", ram_enable, 2'b10);
        chk("t1_wr_write", ram_write, 1);
        chk("t1_wr_ready", write_ready, 1);
        chk("t1_wr_wdata", ram_wdata, {LINE_A5, LINE_A5});
        @(negedge clk);
        set_write(1'b0, 7'd0, 1'b0, '0);
        set_read(1'b1, 7'd5, 1'b1, 4'd3);
        #1;
        chk("t1_rd_ready", lookup_ready, 1);
        chk("t1_rd_enable", ram_enable, 2'b10);
        chk("t1_rd_write", ram_write, 0);
        chk("t1_rd_addr", ram_addr, 7'd5);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        #1;
        chk("t1_rsp_not_yet", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, LINE_A5);
        chk("t1_rsp_id", rsp_id, 4'd3);

        // 2: write and lookup collide, write wins
        @(negedge clk);
        set_write(1'b1, 7'd20, 1'b0, LINE_D1);
        set_read(1'b1, 7'd20, 1'b0, 4'd5);
        #1;
        chk("t2_lookup_blocked", lookup_ready, 0);
        chk("t2_write_wins", ram_write, 1);
        chk("t2_wr_enable", ram_enable, 2'b01);
        @(negedge clk);
        set_write(1'b0, 7'd0, 1'b0, '0);
        #1;
        chk("t2_lookup_ready", lookup_ready, 1);
        chk("t2_rd_enable", ram_enable, 2'b01);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_data", rsp_data, LINE_D1);
        chk("t2_rsp_id", rsp_id, 4'd5);

        // 3: fill lines 0..7 of way 0, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_write(1'b1, 7'(i), 1'b0, pat(i));
        end
        @(negedge clk);
        set_write(1'b0, 7'd0, 1'b0, '0);
        #1;
        chk("t3_drained", rsp_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_read(1'b1, 7'(i), 1'b0, 4'(i));
            #1;
            chk($sformatf("t3_ready_%0d", i), lookup_ready, 1);
            if (i >= 2) begin
                chk($sformatf("t3_valid_%0d", i - 2), rsp_valid, 1);
                chk($sformatf("t3_id_%0d", i - 2), rsp_id, 4'(i - 2));
                chk($sformatf("t3_data_%0d", i - 2), rsp_data, pat(i - 2));
            end
        end
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        #1;
        chk("t3_id_6", rsp_id, 4'd6);
        chk("t3_data_6", rsp_data, pat(6));
        @(negedge clk);
        #1;
        chk("t3_id_7", rsp_id, 4'd7);
        chk("t3_data_7", rsp_data, pat(7));
        @(negedge clk);
        #1;
        chk("t3_empty", rsp_valid, 0);

        // 4: backpressure, two credits only
        @(negedge clk);
        rsp_ready = 1'b0;
        set_read(1'b1, 7'd0, 1'b0, 4'd10);
        #1;
        chk("t4_acc_0", lookup_ready, 1);
        @(negedge clk);
        set_read(1'b1, 7'd1, 1'b0, 4'd11);
        #1;
        chk("t4_acc_1", lookup_ready, 1);
        @(negedge clk);
        set_read(1'b1, 7'd2, 1'b0, 4'd12);
        #1;
        chk("t4_block_a", lookup_ready, 0);
        chk("t4_head_valid", rsp_valid, 1);
        @(negedge clk);
        #1;
        chk("t4_block_b", lookup_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("t4_resume_on_pop", lookup_ready, 1);
        chk("t4_id_10", rsp_id, 4'd10);
        chk("t4_data_10", rsp_data, pat(0));
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        #1;
        chk("t4_id_11", rsp_id, 4'd11);
        chk("t4_data_11", rsp_data, pat(1));
        @(negedge clk);
        #1;
        chk("t4_id_12", rsp_id, 4'd12);
        chk("t4_data_12", rsp_data, pat(2));
        @(negedge clk);
        #1;
        chk("t4_empty", rsp_valid, 0);

        // 5: write right after a read to the same line returns the old data
        @(negedge clk);
        set_write(1'b1, 7'd9, 1'b1, LINE_OLD);
        @(negedge clk);
        set_write(1'b0, 7'd0, 1'b0, '0);
        set_read(1'b1, 7'd9, 1'b1, 4'd6);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        set_write(1'b1, 7'd9, 1'b1, LINE_NEW);
        @(negedge clk);
        set_write(1'b0, 7'd0, 1'b0, '0);
        #1;
        chk("t5_old_data", rsp_data, LINE_OLD);
        chk("t5_id", rsp_id, 4'd6);
        @(negedge clk);
        set_read(1'b1, 7'd9, 1'b1, 4'd7);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        chk("t5_new_data", rsp_data, LINE_NEW);

        // 6: reset with one buffered and one in flight
        @(negedge clk);
        rsp_ready = 1'b0;
        set_read(1'b1, 7'd0, 1'b0, 4'd1);
        @(negedge clk);
        set_read(1'b1, 7'd1, 1'b0, 4'd2);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        #1;
        chk("t6_pre_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_clears", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("t6_post_0", rsp_valid, 0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t6_post_%0d", i), rsp_valid, 0);
        end
        @(negedge clk);
        set_read(1'b1, 7'd3, 1'b0, 4'd9);
        #1;
        chk("t6_fresh_ready", lookup_ready, 1);
        @(negedge clk);
        set_read(1'b0, 7'd0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        chk("t6_fresh_valid", rsp_valid, 1);
        chk("t6_fresh_data", rsp_data, pat(3));
        chk("t6_fresh_id", rsp_id, 4'd9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
